// File: rtl/gate_selftest_pkg.sv
// Shared types and constants for the 2-input gate self-test sequencer.
// Truth tables are indexed by {A,B}; bit 0 is the expected Y for vector 00.
package gate_selftest_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SETTLE,
    ST_SAMPLE,
    ST_FINISH
  } state_e;

  localparam int NUM_VECTORS = 4;
  localparam int TIMER_W     = 8;

  localparam logic [3:0] TT_XNOR = 4'b1001;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/selftest_settle_timer.sv
// Loadable down-counter that times the settle window between driving the
// gate inputs and sampling its output; holds at zero once it gets there.
module selftest_settle_timer
  import gate_selftest_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               dec,
  input  logic [TIMER_W-1:0] load_val,
  output logic               zero
);

  logic [TIMER_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/gate_selftest_ctrl.sv
// Sequencer that walks a 2-input gate through all four input vectors, checks
// Y against TRUTH_TABLE after a settle window and reports pass/mask/count.
module gate_selftest_ctrl
  import gate_selftest_pkg::*;
#(
  parameter logic [3:0] TRUTH_TABLE   = TT_XNOR,
  parameter int         SETTLE_CYCLES = 2,
  parameter int         LOOPS         = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  output logic       gate_a,
  output logic       gate_b,
  input  logic       gate_y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] mismatch_mask,
  output logic [7:0] err_count
);

  localparam logic [TIMER_W-1:0] SETTLE_LOAD = TIMER_W'(SETTLE_CYCLES - 1);
  localparam logic [7:0]         LAST_LOOP   = 8'(LOOPS - 1);
  localparam logic [1:0]         LAST_IDX    = 2'(NUM_VECTORS - 1);

  state_e     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] loop_q, loop_d;
  logic       gate_a_q, gate_a_d;
  logic       gate_b_q, gate_b_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic       aborted_q, aborted_d;
  logic [3:0] mask_q, mask_d;
  logic [7:0] err_q, err_d;

  logic       timer_load, timer_dec, timer_zero;
  logic       mismatch;

  selftest_settle_timer u_settle_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .dec      (timer_dec),
    .load_val (SETTLE_LOAD),
    .zero     (timer_zero)
  );

  assign mismatch = (gate_y != TRUTH_TABLE[idx_q]);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    loop_d     = loop_q;
    gate_a_d   = gate_a_q;
    gate_b_d   = gate_b_q;
    pass_d     = pass_q;
    aborted_d  = aborted_q;
    mask_d     = mask_q;
    err_d      = err_q;
    timer_load = 1'b0;
    timer_dec  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // abort beats start: a simultaneous request never launches a run
        if (start && !abort) begin
          state_d   = ST_APPLY;
          idx_d     = 2'd0;
          loop_d    = 8'd0;
          pass_d    = 1'b0;
          aborted_d = 1'b0;
          mask_d    = 4'b0000;
          err_d     = 8'd0;
        end
      end
      ST_APPLY: begin
        timer_load = 1'b1;
        state_d    = abort ? ST_FINISH : ST_SETTLE;
      end
      ST_SETTLE: begin
        timer_dec = 1'b1;
        if (abort) begin
          state_d = ST_FINISH;
        end else if (timer_zero) begin
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        // the compare is recorded even when abort cuts the run short here
        if (mismatch) begin
          mask_d[idx_q] = 1'b1;
          err_d         = sat_inc8(err_q);
        end
        if (abort) begin
          state_d = ST_FINISH;
        end else if (idx_q != LAST_IDX) begin
          idx_d   = idx_q + 2'd1;
          state_d = ST_APPLY;
        end else if (loop_q != LAST_LOOP) begin
          idx_d   = 2'd0;
          loop_d  = loop_q + 8'd1;
          state_d = ST_APPLY;
        end else begin
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
        pass_d  = !aborted_q && !abort && (err_q == 8'd0);
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (abort && (state_q inside {ST_APPLY, ST_SETTLE, ST_SAMPLE})) begin
      aborted_d = 1'b1;
    end

    // Inputs change on entry to APPLY so they are stable for the whole vector.
    if (state_d == ST_APPLY) begin
      {gate_a_d, gate_b_d} = idx_d;
    end

    busy_d = (state_d inside {ST_APPLY, ST_SETTLE, ST_SAMPLE});
    done_d = (state_q == ST_FINISH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= 2'd0;
      loop_q    <= 8'd0;
      gate_a_q  <= 1'b0;
      gate_b_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      aborted_q <= 1'b0;
      mask_q    <= 4'b0000;
      err_q     <= 8'd0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      loop_q    <= loop_d;
      gate_a_q  <= gate_a_d;
      gate_b_q  <= gate_b_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      aborted_q <= aborted_d;
      mask_q    <= mask_d;
      err_q     <= err_d;
    end
  end

  assign gate_a        = gate_a_q;
  assign gate_b        = gate_b_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign mismatch_mask = mask_q;
  assign err_count     = err_q;

endmodule

// File: tb/tb_gate_selftest_ctrl.sv
// Bench for gate_selftest_ctrl: four differently parameterised sequencers,
// each driving a behavioural gate model; results checked from a done-driven queue.
module tb_gate_selftest_ctrl;

  localparam logic [1:0] M_XNOR  = 2'd0;
  localparam logic [1:0] M_STUCK = 2'd1;
  localparam logic [1:0] M_XOR   = 2'd2;

  typedef struct {
    logic       pass;
    logic [3:0] mask;
    logic [7:0] cnt;
    int         lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_w [4];
  logic       abort_w [4];
  logic       a_w     [4];
  logic       b_w     [4];
  logic       y_w     [4];
  logic       busy_w  [4];
  logic       done_w  [4];
  logic       pass_w  [4];
  logic [3:0] mask_w  [4];
  logic [7:0] cnt_w   [4];
  logic [1:0] mode    [4];

  exp_t exp_q [4][$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rise_t [4];
  logic busy_prev [4] = '{default: 1'b0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic gate_fn(input logic [1:0] m, input logic a, input logic b);
    case (m)
      M_XNOR:  return ~(a ^ b);
      M_STUCK: return 1'b0;
      default: return a ^ b;
    endcase
  endfunction

  always_comb begin
    for (int i = 0; i < 4; i++) y_w[i] = gate_fn(mode[i], a_w[i], b_w[i]);
  end

  // dut0: defaults; dut1: LOOPS=3; dut2: XOR table; dut3: shortest settle, counter saturation
  gate_selftest_ctrl u_dut0 (
    .clk(clk), .rst(rst), .start(start_w[0]), .abort(abort_w[0]),
    .gate_a(a_w[0]), .gate_b(b_w[0]), .gate_y(y_w[0]), .busy(busy_w[0]),
    .done(done_w[0]), .pass(pass_w[0]), .mismatch_mask(mask_w[0]), .err_count(cnt_w[0]));

  gate_selftest_ctrl #(.LOOPS(3)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_w[1]), .abort(abort_w[1]),
    .gate_a(a_w[1]), .gate_b(b_w[1]), .gate_y(y_w[1]), .busy(busy_w[1]),
    .done(done_w[1]), .pass(pass_w[1]), .mismatch_mask(mask_w[1]), .err_count(cnt_w[1]));

  gate_selftest_ctrl #(.TRUTH_TABLE(4'b0110)) u_dut2 (
    .clk(clk), .rst(rst), .start(start_w[2]), .abort(abort_w[2]),
    .gate_a(a_w[2]), .gate_b(b_w[2]), .gate_y(y_w[2]), .busy(busy_w[2]),
    .done(done_w[2]), .pass(pass_w[2]), .mismatch_mask(mask_w[2]), .err_count(cnt_w[2]));

  gate_selftest_ctrl #(.SETTLE_CYCLES(1), .LOOPS(64)) u_dut3 (
    .clk(clk), .rst(rst), .start(start_w[3]), .abort(abort_w[3]),
    .gate_a(a_w[3]), .gate_b(b_w[3]), .gate_y(y_w[3]), .busy(busy_w[3]),
    .done(done_w[3]), .pass(pass_w[3]), .mismatch_mask(mask_w[3]), .err_count(cnt_w[3]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic p, input logic [3:0] m, input logic [7:0] c, input int l);
    exp_t e;
    e.pass = p; e.mask = m; e.cnt = c; e.lat = l;
    return e;
  endfunction

  // Scoreboard monitor: latency measured from the busy rise of each run.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (busy_w[i] && !busy_prev[i]) rise_t[i] = cyc;
      busy_prev[i] = busy_w[i];
      if (done_w[i]) begin
        if (exp_q[i].size() == 0) begin
          chk($sformatf("dut%0d_unexpected_done", i), 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q[i].pop_front();
          chk($sformatf("dut%0d_pass", i), 32'(pass_w[i]), 32'(e.pass));
          chk($sformatf("dut%0d_mask", i), 32'(mask_w[i]), 32'(e.mask));
          chk($sformatf("dut%0d_err_count", i), 32'(cnt_w[i]), 32'(e.cnt));
          chk($sformatf("dut%0d_latency", i), 32'(cyc - rise_t[i]), 32'(e.lat));
        end
      end
    end
  end

  task automatic wait_done(input int i, input int budget);
    int n = 0;
    while (!done_w[i] && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!done_w[i]) chk($sformatf("dut%0d_done_timeout", i), 32'd0, 32'd1);
  endtask

  task automatic pulse_start(input int i);
    start_w[i] = 1'b1;
    @(negedge clk);
    start_w[i] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      start_w[i] = 1'b0;
      abort_w[i] = 1'b0;
    end
    mode[0] = M_XNOR; mode[1] = M_XOR; mode[2] = M_XOR; mode[3] = M_XOR;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++)
      chk($sformatf("dut%0d_reset_state", i),
          32'({a_w[i], b_w[i], busy_w[i], done_w[i], pass_w[i], mask_w[i], cnt_w[i]}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Good XNOR gate: each vector held 4 cycles, done 17 cycles after start.
    exp_q[0].push_back(mk(1'b1, 4'b0000, 8'd0, 17));
    pulse_start(0);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("vector_cycle%0d", k), 32'({a_w[0], b_w[0]}), 32'(k / 4));
      @(negedge clk);
    end
    wait_done(0, 5);
    chk("idle_holds_last_vector", 32'({a_w[0], b_w[0]}), 32'd3);
    @(negedge clk);

    // Stuck-at-0 gate fails vectors 00 and 11.
    mode[0] = M_STUCK;
    exp_q[0].push_back(mk(1'b0, 4'b1001, 8'd2, 17));
    pulse_start(0);
    wait_done(0, 30);
    @(negedge clk);

    // LOOPS=3 with inverted output, then a clean rerun clears the results.
    exp_q[1].push_back(mk(1'b0, 4'b1111, 8'd12, 49));
    pulse_start(1);
    wait_done(1, 60);
    @(negedge clk);
    mode[1] = M_XNOR;
    exp_q[1].push_back(mk(1'b1, 4'b0000, 8'd0, 49));
    pulse_start(1);
    wait_done(1, 60);
    @(negedge clk);

    // Abort during SETTLE of vector 2 keeps only vector 0..1 results.
    exp_q[0].push_back(mk(1'b0, 4'b0001, 8'd1, 11));
    pulse_start(0);
    repeat (9) @(negedge clk);
    abort_w[0] = 1'b1;
    @(negedge clk);
    abort_w[0] = 1'b0;
    wait_done(0, 5);
    @(negedge clk);

    // Abort together with start in IDLE: nothing starts.
    start_w[0] = 1'b1;
    abort_w[0] = 1'b1;
    @(negedge clk);
    start_w[0] = 1'b0;
    abort_w[0] = 1'b0;
    chk("abort_start_no_busy0", 32'(busy_w[0]), 32'd0);
    @(negedge clk);
    chk("abort_start_no_busy1", 32'(busy_w[0]), 32'd0);

    // Asynchronous reset in SAMPLE of vector 1 (partial mask/count present).
    pulse_start(0);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_sample_outputs",
        32'({a_w[0], b_w[0], busy_w[0], done_w[0], pass_w[0], mask_w[0], cnt_w[0]}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mode[0] = M_XNOR;
    exp_q[0].push_back(mk(1'b1, 4'b0000, 8'd0, 17));
    pulse_start(0);
    wait_done(0, 30);
    @(negedge clk);

    // XOR table with XOR gate, start held through the run and FINISH.
    exp_q[2].push_back(mk(1'b1, 4'b0000, 8'd0, 17));
    exp_q[2].push_back(mk(1'b1, 4'b0000, 8'd0, 17));
    start_w[2] = 1'b1;
    @(negedge clk);
    wait_done(2, 30);
    chk("no_restart_from_finish", 32'(busy_w[2]), 32'd0);
    @(negedge clk);
    chk("restart_from_idle", 32'(busy_w[2]), 32'd1);
    start_w[2] = 1'b0;
    wait_done(2, 30);
    @(negedge clk);

    // 256 mismatches saturate the error counter; settle of one cycle.
    exp_q[3].push_back(mk(1'b0, 4'b1111, 8'hFF, 769));
    pulse_start(3);
    wait_done(3, 800);

    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++)
      chk($sformatf("dut%0d_scoreboard_drained", i), 32'(exp_q[i].size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
